// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: opcode set and control FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    MULT = 3'd1,
    SUB  = 3'd2,
    XOR  = 3'd3,
    AND  = 3'd4,
    OR   = 3'd5,
    SHL  = 3'd6,
    SHR  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle.
// The last partial product is folded in combinationally, so done/product
// are valid on the WIDTH-th edge after start, ready to be registered there.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

  logic                 busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   partial_s;
  logic [2*WIDTH-1:0]   sum_s;

  assign partial_s = mplier_q[0] ? mcand_q : ZERO_2W;
  assign sum_s     = acc_q + partial_s;
  assign done      = busy_q && (cnt_q == CNT_LAST);
  assign product   = sum_s;

  // Load operands on start, otherwise advance one shift-add step while busy
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = {CW{1'b0}};
      mcand_d  = {{WIDTH{1'b0}}, op_a};
      mplier_d = op_b;
      acc_d    = ZERO_2W;
    end else if (busy_q) begin
      acc_d    = sum_s;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = {CW{1'b0}};
      end else begin
        cnt_d  = cnt_q + CNT_ONE;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers; reset aborts any product in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      mcand_q  <= ZERO_2W;
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= ZERO_2W;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked 8-op ALU with registered result/flags held until consumed.
// Single-cycle ops land in HOLD one edge after acceptance; MULT detours
// through MUL_BUSY for WIDTH edges.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     operand1,
  input  logic [WIDTH-1:0]     operand2,
  input  opcode_t              opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 carry
);

  localparam logic [2*WIDTH-1:0] ZERO_2W   = {(2*WIDTH){1'b0}};
  localparam logic [2*WIDTH-1:0] SHIFT_MAX = (2*WIDTH)'(2*WIDTH);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept_s;
  logic                 mul_start_s;
  logic                 mul_done_s;
  logic [2*WIDTH-1:0]   mul_product_s;
  logic [2*WIDTH-1:0]   a_ext_s, b_ext_s;
  logic [2*WIDTH-1:0]   alu_res_s;
  logic                 alu_carry_s;

  // in_ready is forced low while reset is held so nothing is accepted then
  assign in_ready    = !reset && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_HOLD) && out_ready));
  assign accept_s    = in_valid && in_ready;
  assign mul_start_s = accept_s && (opcode == MULT);
  assign a_ext_s     = {{WIDTH{1'b0}}, operand1};
  assign b_ext_s     = {{WIDTH{1'b0}}, operand2};

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start_s),
    .op_a    (operand1),
    .op_b    (operand2),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // Single-cycle datapath; shift amounts of 2*WIDTH or more give 0
  always_comb begin
    alu_res_s   = ZERO_2W;
    alu_carry_s = 1'b0;
    case (opcode)
      ADD: begin
        alu_res_s   = a_ext_s + b_ext_s;
        alu_carry_s = alu_res_s[WIDTH];
      end
      SUB: begin
        alu_res_s   = a_ext_s - b_ext_s;
        alu_carry_s = (operand1 < operand2);
      end
      XOR: alu_res_s = a_ext_s ^ b_ext_s;
      AND: alu_res_s = a_ext_s & b_ext_s;
      OR:  alu_res_s = a_ext_s | b_ext_s;
      SHL: begin
        if (b_ext_s >= SHIFT_MAX) alu_res_s = ZERO_2W;
        else                      alu_res_s = a_ext_s << operand2;
      end
      SHR: begin
        if (b_ext_s >= SHIFT_MAX) alu_res_s = ZERO_2W;
        else                      alu_res_s = a_ext_s >> operand2;
      end
      default: alu_res_s = ZERO_2W;
    endcase
  end

  // FSM next state and output-register updates
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept_s) begin
          if (opcode == MULT) begin
            state_d     = ST_MUL_BUSY;
            out_valid_d = 1'b0;
          end else begin
            state_d     = ST_HOLD;
            result_d    = alu_res_s;
            zero_d      = (alu_res_s == ZERO_2W);
            carry_d     = alu_carry_s;
            out_valid_d = 1'b1;
          end
        end else if ((state_q == ST_HOLD) && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done_s) begin
          state_d     = ST_HOLD;
          result_d    = mul_product_s;
          zero_d      = (mul_product_s == ZERO_2W);
          carry_d     = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= ZERO_2W;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8).
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   operand1;
  logic [WIDTH-1:0]   operand2;
  opcode_t            opcode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               zero;
  logic               carry;

  int n_checks = 0;
  int n_errors = 0;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand1  (operand1),
    .operand2  (operand2),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one edge (caller ensures in_ready)
  task automatic issue(input opcode_t op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    opcode   = op;
    operand1 = a;
    operand2 = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operand1 = 8'h00; operand2 = 8'h00; opcode = ADD;

    // Reset
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_zero_carry", {30'd0, zero, carry}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD / SUB back-to-back with draining consumer
    out_ready = 1'b1;
    issue(ADD, 8'd200, 8'd100);
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", {16'd0, result}, 32'd300);
    check("add_flags", {30'd0, carry, zero}, 32'd2);
    issue(SUB, 8'd5, 8'd9);
    check("sub_neg_result", {16'd0, result}, 32'h0000FFFC);
    check("sub_neg_carry", {31'd0, carry}, 32'd1);
    issue(SUB, 8'd7, 8'd7);
    check("sub_eq_result", {16'd0, result}, 32'd0);
    check("sub_eq_flags", {30'd0, zero, carry}, 32'd2);
    tick();
    check("drain_idle", {31'd0, out_valid}, 32'd0);

    // MULT latency
    out_ready = 1'b0;
    issue(MULT, 8'd255, 8'd255);
    check("mul_busy_ready_0", {31'd0, in_ready}, 32'd0);
    check("mul_busy_valid_0", {31'd0, out_valid}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("mul_busy_ready_%0d", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("mul_busy_valid_%0d", i), {31'd0, out_valid}, 32'd0);
    end
    tick();
    check("mul_done_valid", {31'd0, out_valid}, 32'd1);
    check("mul_result", {16'd0, result}, 32'h0000FE01);
    check("mul_flags", {30'd0, zero, carry}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("mul_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: XOR held while consumer stalls
    out_ready = 1'b0;
    issue(XOR, 8'hF0, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_result_%0d", i), {16'd0, result}, 32'h000000CC);
      check($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    issue(AND, 8'hF0, 8'h3C);
    check("and_result", {16'd0, result}, 32'h00000030);
    check("and_valid", {31'd0, out_valid}, 32'd1);

    // Shifts and OR
    issue(SHL, 8'h81, 8'd4);
    check("shl4_result", {16'd0, result}, 32'h00000810);
    issue(SHL, 8'h81, 8'd16);
    check("shl16_result", {16'd0, result}, 32'd0);
    check("shl16_zero", {31'd0, zero}, 32'd1);
    issue(SHR, 8'h80, 8'd7);
    check("shr7_result", {16'd0, result}, 32'h00000001);
    issue(OR, 8'hF0, 8'h0F);
    check("or_result", {16'd0, result}, 32'h000000FF);
    tick();

    // Reset mid-MULT
    out_ready = 1'b0;
    issue(MULT, 8'd12, 8'd13);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("midmul_rst_valid", {31'd0, out_valid}, 32'd0);
    check("midmul_rst_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("midmul_quiet_%0d", i), {31'd0, out_valid}, 32'd0);
    end
    check("midmul_idle_ready", {31'd0, in_ready}, 32'd1);
    issue(MULT, 8'd3, 8'd4);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("mul2_busy_%0d", i), {31'd0, out_valid}, 32'd0);
      tick();
    end
    tick();
    check("mul2_valid", {31'd0, out_valid}, 32'd1);
    check("mul2_result", {16'd0, result}, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, handshaked successor to the combinational 4-op ALU used in the homework testbenches.
- Operand width is generic and the opcode set grows to 8 operations.
- Adds valid/ready flow control on both sides, a registered result and status flags.
- MULT is sequential (shift-add, one partial product per cycle); all other ops complete in one cycle.
- Sits between a stimulus driver and a result checker/scoreboard; the result is held until consumed.

Parameters:
WIDTH, 8, operand width in bits (>= 2); result width is 2*WIDTH.

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept an operation this cycle
operand1  input  WIDTH  first operand, unsigned
operand2  input  WIDTH  second operand, unsigned
opcode  input  opcode_t  operation select (alu_pkg)
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result this cycle
result  output  2*WIDTH  registered result
zero  output  1  result == 0
carry  output  1  ADD carry-out / SUB borrow; 0 for all other ops

Behaviour:
- Reset is synchronous and active-high and acts on the posedge of clk. While it is asserted:
  - state returns to IDLE, aborting any MULT in progress;
  - out_valid=0, result=0, zero=0, carry=0, in_ready=0.
  - in_ready is 1 from the first cycle after reset deasserts.
- FSM states: IDLE, MUL_BUSY, HOLD.
- Acceptance happens on a posedge with in_valid && in_ready. Operands and opcode are captured only then; they are don't-care otherwise.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This allows back-to-back issue when the consumer drains every cycle.
- Non-MULT accepted at edge N: result, flags and out_valid are visible after edge N. Latency is 1, next state is HOLD.
- MULT accepted at edge N:
  - goes to MUL_BUSY, performs one shift-add step per edge, with an internal counter running from 0 to WIDTH-1;
  - the final product is registered and the state moves to HOLD at edge N+WIDTH. Latency is WIDTH;
  - in_ready=0 and out_valid=0 throughout MUL_BUSY.
- HOLD:
  - result, flags and out_valid=1 remain stable until out_ready=1;
  - out_ready=1 with no new acceptance: go to IDLE, out_valid=0;
  - out_ready=1 with a simultaneous acceptance: load the new op (HOLD again, or MUL_BUSY for MULT).
- out_ready is ignored when out_valid=0.
- Arithmetic: operands are zero-extended to 2*WIDTH.
  - ADD: op1+op2; carry = bit WIDTH of the sum.
  - SUB: op1-op2 modulo 2^(2W), so a negative result is sign-extended; carry = (op1<op2).
  - MULT: full unsigned product.
  - XOR, AND, OR: bitwise, upper WIDTH bits 0.
  - SHL: op1<<op2 in 2W bits.
  - SHR: op1>>op2.
  - Any shift amount >= 2*WIDTH gives 0.
- zero is computed on the final 2W-bit result for every op.
- Reset mid-MULT discards the partial product; the next accepted op is unaffected.

Decomposition:
- alu_pkg holds typedef enum logic [2:0] opcode_t {ADD=0, MULT=1, SUB=2, XOR=3, AND=4, OR=5, SHL=6, SHR=7} and the FSM state enum.
- Sub-module alu_mul_seq contains the shift-add multiplier datapath and step counter.
  - Inputs: start and the two operands. Outputs: done and the product.
- The top level owns the FSM, the handshake, the single-cycle ops and the output register.

Test Plan:
- Reset check (WIDTH=8): reset high 2 cycles -> out_valid=0, result=0, in_ready=0; in_ready=1 on the first cycle after reset drops.
- ADD and SUB flags:
  - ADD 200+100 with out_ready=1 -> next cycle result=16'd300, carry=1, zero=0.
  - SUB 5-9 -> result=16'hFFFC, carry=1.
  - SUB 7-7 -> result=0, zero=1, carry=0.
- MULT latency: MULT 255*255 -> in_ready=0 for 8 cycles; out_valid rises exactly 8 cycles after acceptance with result=16'hFE01.
- Backpressure:
  - XOR 8'hF0^8'h3C with out_ready=0 for 5 cycles -> result=16'h00CC held, out_valid=1 stable, in_ready=0.
  - Release out_ready together with in_valid for AND 8'hF0&8'h3C -> the next cycle shows 16'h0030.
- Shifts: SHL 8'h81 by 4 -> 16'h0810; SHL by 16 -> 0 with zero=1; SHR 8'h80 by 7 -> 16'h0001.
- Reset mid-MULT: reset asserted 3 cycles into MULT 12*13 -> out_valid stays 0; a subsequent MULT 3*4 gives 16'd12 after 8 cycles.
